instr_mem_loader: RTL and testbench

- Write-side counterpart of the instruction memory: a program loader that accepts a byte stream over a valid/ready handshake.
- Assembles each group of 3 bytes into one 19-bit instruction word and issues one write per word to the instruction memory's 12-bit-addressed, 4096-entry write port.
- Sits between the host/boot byte source and the instruction memory; the processor is held off while busy is high.

---
 rtl/instr_mem_loader.sv | 123 ++++++++++++
 tb/tb_instr_mem_loader.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/instr_mem_loader.sv
// instr_mem_loader: turns a valid/ready byte stream (address, count, 3-byte words)
// into one instruction-memory write per 19-bit word.
module instr_mem_loader #(
    parameter int ADDR_W  = 12,
    parameter int INSTR_W = 19,
    parameter int DEPTH   = 4096
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [7:0]         in_data,
    input  logic               in_valid,
    output logic               in_ready,
    output logic               mem_we,
    output logic [ADDR_W-1:0]  mem_addr,
    output logic [INSTR_W-1:0] mem_wdata,
    output logic               busy,
    output logic               done,
    output logic               error
);
    typedef enum logic [3:0] {IDLE, ADDR_LO, ADDR_HI, CNT_LO, CNT_HI, B0, B1, B2, WRITE, DONE} state_t;

    state_t             state_q, state_d;
    logic [ADDR_W-1:0]  addr_q, addr_d, mem_addr_q, mem_addr_d;
    logic [ADDR_W:0]    cnt_q, cnt_d;
    logic [15:0]        word_q, word_d;
    logic [INSTR_W-1:0] mem_wdata_q, mem_wdata_d;
    logic               error_q, error_d;
    logic               in_ready_q, mem_we_q, busy_q, done_q;
    logic               accept;

    assign accept = in_valid && in_ready_q;

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        cnt_d       = cnt_q;
        word_d      = word_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        error_d     = error_q;
        case (state_q)
            IDLE: if (start) begin
                state_d = ADDR_LO;
                error_d = 1'b0;
            end
            ADDR_LO: if (accept) begin
                addr_d[7:0] = in_data;
                state_d     = ADDR_HI;
            end
            ADDR_HI: if (accept) begin
                addr_d[11:8] = in_data[3:0];
                state_d      = CNT_LO;
            end
            CNT_LO: if (accept) begin
                cnt_d[7:0] = in_data;
                state_d    = CNT_HI;
            end
            CNT_HI: if (accept) begin
                cnt_d   = {in_data[4:0], cnt_q[7:0]};
                error_d = cnt_d > 13'(DEPTH);
                state_d = (cnt_d == '0 || error_d) ? DONE : B0;
            end
            B0: if (accept) begin
                word_d[7:0] = in_data;
                state_d     = B1;
            end
            B1: if (accept) begin
                word_d[15:8] = in_data;
                state_d      = B2;
            end
            // Stray high bits in the last byte flag an error but the word still goes out.
            B2: if (accept) begin
                mem_addr_d  = addr_q;
                mem_wdata_d = {in_data[2:0], word_q};
                error_d     = error_q | (|in_data[7:3]);
                state_d     = WRITE;
            end
            WRITE: begin
                addr_d  = addr_q + 12'd1;
                cnt_d   = cnt_q - 13'd1;
                state_d = (cnt_q > 13'd1) ? B0 : DONE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            cnt_q       <= '0;
            word_q      <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            error_q     <= 1'b0;
            in_ready_q  <= 1'b0;
            mem_we_q    <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            cnt_q       <= cnt_d;
            word_q      <= word_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            error_q     <= error_d;
            in_ready_q  <= state_d inside {[ADDR_LO:B2]};
            mem_we_q    <= state_d == WRITE;
            busy_q      <= !(state_d inside {IDLE, DONE});
            done_q      <= state_d == DONE;
        end
    end

    assign in_ready  = in_ready_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign error     = error_q;
endmodule

// File: tb/tb_instr_mem_loader.sv
// tb_instr_mem_loader: directed scenarios for the byte-stream program loader.
module tb_instr_mem_loader;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic [7:0]  in_data = 8'h00;
    logic        in_valid = 1'b0;
    logic        in_ready, mem_we, busy, done, error;
    logic [11:0] mem_addr;
    logic [18:0] mem_wdata;
    int          n_cmp = 0;
    int          n_err = 0;
    int          n_we = 0;

    instr_mem_loader dut (
        .clk(clk), .rst(rst), .start(start), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .busy(busy), .done(done), .error(error)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (mem_we) n_we++;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b);
        int guard = 0;
        in_data  = b;
        in_valid = 1'b1;
        while (!in_ready && guard < 50) begin
            tick();
            guard++;
        end
        n_cmp++;
        if (guard >= 50) begin n_err++; $display("FAIL send_timeout: in_ready=%b want 1", in_ready); end
        tick();
        in_valid = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done();
        int guard = 0;
        while (!done && guard < 20) begin
            tick();
            guard++;
        end
        n_cmp++;
        if (done !== 1'b1) begin n_err++; $display("FAIL wait_done: done=%b want 1", done); end
        tick();
    endtask

    task automatic test_reset();
        tick();
        n_cmp++;
        if ({in_ready, mem_we, busy, done, error, mem_addr, mem_wdata} !== '0) begin
            n_err++; $display("FAIL reset_outputs: got %h want 0", {in_ready, mem_we, busy, done, error, mem_addr, mem_wdata});
        end
        rst = 1'b1;
        tick();
        n_cmp++;
        if ({in_ready, busy} !== 2'b00) begin n_err++; $display("FAIL reset_idle: ready/busy=%b want 00", {in_ready, busy}); end
    endtask

    task automatic test_basic();
        pulse_start();
        n_cmp++;
        if ({busy, in_ready} !== 2'b11) begin n_err++; $display("FAIL basic_start: busy/ready=%b want 11", {busy, in_ready}); end
        send(8'h01); send(8'h00); send(8'h02); send(8'h00);
        send(8'h60); send(8'h53); send(8'h02);
        n_cmp++;
        if ({mem_we, in_ready, mem_addr, mem_wdata} !== {1'b1, 1'b0, 12'h001, 19'h25360}) begin
            n_err++; $display("FAIL basic_w0: we/rdy=%b addr=%h data=%h want 10 001 25360", {mem_we, in_ready}, mem_addr, mem_wdata);
        end
        send(8'h40); send(8'h1C); send(8'h00);
        n_cmp++;
        if ({mem_we, busy, mem_addr, mem_wdata} !== {1'b1, 1'b1, 12'h002, 19'h01C40}) begin
            n_err++; $display("FAIL basic_w1: we/busy=%b addr=%h data=%h want 11 002 01c40", {mem_we, busy}, mem_addr, mem_wdata);
        end
        tick();
        n_cmp++;
        if ({done, busy, mem_we, error} !== 4'b1000) begin n_err++; $display("FAIL basic_done: done/busy/we/err=%b want 1000", {done, busy, mem_we, error}); end
        tick();
        n_cmp++;
        if (done !== 1'b0) begin n_err++; $display("FAIL basic_done_len: done=%b want 0", done); end
    endtask

    task automatic test_wrap();
        pulse_start();
        send(8'hFF); send(8'hFF); send(8'h02); send(8'h00);
        send(8'h11); send(8'h22); send(8'h03);
        n_cmp++;
        if ({mem_we, mem_addr, mem_wdata} !== {1'b1, 12'hFFF, 19'h32211}) begin
            n_err++; $display("FAIL wrap_w0: we=%b addr=%h data=%h want 1 fff 32211", mem_we, mem_addr, mem_wdata);
        end
        send(8'h44); send(8'h55); send(8'h06);
        n_cmp++;
        if ({mem_we, mem_addr, mem_wdata} !== {1'b1, 12'h000, 19'h65544}) begin
            n_err++; $display("FAIL wrap_w1: we=%b addr=%h data=%h want 1 000 65544", mem_we, mem_addr, mem_wdata);
        end
        wait_done();
    endtask

    task automatic test_count0();
        int we0 = n_we;
        pulse_start();
        send(8'h34); send(8'h02); send(8'h00); send(8'hE0);
        n_cmp++;
        if ({in_ready, done, busy, error} !== 4'b0100) begin
            n_err++; $display("FAIL count0_done: rdy/done/busy/err=%b want 0100", {in_ready, done, busy, error});
        end
        tick();
        n_cmp++;
        if (n_we !== we0) begin n_err++; $display("FAIL count0_nowrite: writes=%0d want %0d", n_we, we0); end
    endtask

    task automatic test_overflow();
        int we0 = n_we;
        pulse_start();
        send(8'h00); send(8'h00); send(8'h01); send(8'h10);
        n_cmp++;
        if ({done, error, in_ready} !== 3'b110) begin n_err++; $display("FAIL ovf_done: done/err/rdy=%b want 110", {done, error, in_ready}); end
        tick(); tick();
        n_cmp++;
        if ({error, n_we == we0} !== 2'b11) begin n_err++; $display("FAIL ovf_sticky: err=%b writes=%0d want 1 %0d", error, n_we, we0); end
        pulse_start();
        n_cmp++;
        if ({error, in_ready} !== 2'b01) begin n_err++; $display("FAIL ovf_clear: err/rdy=%b want 01", {error, in_ready}); end
        send(8'h00); send(8'h00); send(8'h00); send(8'h00);
        tick();
    endtask

    task automatic test_reset_midload();
        int we0 = n_we;
        pulse_start();
        send(8'h00); send(8'h00); send(8'h00); send(8'h10);
        n_cmp++;
        if ({error, in_ready, busy} !== 3'b011) begin n_err++; $display("FAIL max_count: err/rdy/busy=%b want 011", {error, in_ready, busy}); end
        send(8'hAB);
        #2 rst = 1'b0;
        #1;
        n_cmp++;
        if ({in_ready, mem_we, busy, done, error, mem_addr, mem_wdata} !== '0) begin
            n_err++; $display("FAIL async_reset: got %h want 0", {in_ready, mem_we, busy, done, error, mem_addr, mem_wdata});
        end
        tick();
        rst = 1'b1;
        tick(); tick();
        n_cmp++;
        if ({in_ready, busy, n_we == we0} !== 3'b001) begin
            n_err++; $display("FAIL reset_after: rdy/busy=%b writes=%0d want 00 %0d", {in_ready, busy}, n_we, we0);
        end
        pulse_start();
        n_cmp++;
        if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_restart: rdy=%b want 1", in_ready); end
        send(8'h00); send(8'h00); send(8'h00); send(8'h00);
        tick();
    endtask

    task automatic test_bubbles();
        logic [7:0] bytes [10] = '{8'h10, 8'h00, 8'h02, 8'h00, 8'hAA, 8'hBB, 8'hF8, 8'h01, 8'h02, 8'h07};
        pulse_start();
        for (int i = 0; i < 10; i++) begin
            send(bytes[i]);
            if (i == 6) begin
                n_cmp++;
                if ({mem_we, error, mem_addr, mem_wdata} !== {2'b11, 12'h010, 19'h0BBAA}) begin
                    n_err++; $display("FAIL bub_w0: we/err=%b addr=%h data=%h want 11 010 0bbaa", {mem_we, error}, mem_addr, mem_wdata);
                end
            end
            if (i == 9) begin
                n_cmp++;
                if ({mem_we, mem_addr, mem_wdata} !== {1'b1, 12'h011, 19'h70201}) begin
                    n_err++; $display("FAIL bub_w1: we=%b addr=%h data=%h want 1 011 70201", mem_we, mem_addr, mem_wdata);
                end
            end
            start = (i == 2);
            tick();
            start = 1'b0;
        end
        n_cmp++;
        if ({done, busy, error} !== 3'b101) begin n_err++; $display("FAIL bub_done: done/busy/err=%b want 101", {done, busy, error}); end
        tick();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_wrap();
        test_count0();
        test_overflow();
        test_reset_midload();
        test_bubbles();
        tick();
        n_cmp++;
        if (n_we !== 6) begin n_err++; $display("FAIL total_writes: got %0d want 6", n_we); end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
